// File: rtl/tte_pkg.sv
// -----------------------------------------------------------------------------
// tte_pkg
// Shared declarations for the two-term weight encoder:
//   - tte_state_t   : controller states (IDLE .. DONE)
//   - tte_params_ok : elaboration-time check that the shift-index width N can
//                     hold every leading shift. b_i reaches W_N on the minus
//                     path, so 2^N must exceed W_N.
// -----------------------------------------------------------------------------
package tte_pkg;

    localparam int TTE_W_N_DEFAULT = 8;
    localparam int TTE_N_DEFAULT   = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN_W = 3'd1,
        RESID  = 3'd2,
        SCAN_R = 3'd3,
        ROUND  = 3'd4,
        DONE   = 3'd5
    } tte_state_t;

    function automatic bit tte_params_ok(input int w_n, input int n);
        return (1 << n) > w_n;
    endfunction

endpackage

// File: rtl/tte_lod_scanner.sv
// -----------------------------------------------------------------------------
// tte_lod_scanner
// Serial leading-one detector. A start pulse loads data and examines its MSB
// in the same cycle; each following cycle examines the next lower bit. done
// pulses for one cycle after the scan ends; found/index then hold until the
// next start.
//
// Optional build macro: TTE_EARLY_EXIT_EN
//   defined   : the scan ends in the cycle the first set bit is examined
//   undefined : the scan always examines all W_N bits
//
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset
//   start  in   load data and begin a scan
//   data   in   W_N  word to scan
//   done   out  one-cycle pulse when the scan is finished
//   found  out  a set bit was seen
//   index  out  N    position of the highest set bit (0 when none)
// -----------------------------------------------------------------------------
module tte_lod_scanner #(
    parameter int W_N = 8,
    parameter int N   = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W_N-1:0] data,
    output logic           done,
    output logic           found,
    output logic [N-1:0]   index
);

    logic [W_N-1:0] shreg;
    logic [N-1:0]   pos;
    logic           busy;

    logic [W_N-1:0] cur_word;
    logic [N-1:0]   cur_pos;
    logic           cur_found;
    logic           active;
    logic           hit;
    logic           last;
    logic           finish;

    // The start cycle is itself the first examination, taken straight from
    // the data input rather than from the shift register.
    // NOTE: every signal written in always_comb gets a default first so no
    // path through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        cur_word  = shreg;
        cur_pos   = pos;
        cur_found = found;
        if (start) begin
            cur_word  = data;
            cur_pos   = N'(W_N - 1);
            cur_found = 1'b0;
        end
    end

    assign active = start || busy;
    assign hit    = cur_word[W_N-1] && !cur_found;
    assign last   = (cur_pos == '0);

`ifdef TTE_EARLY_EXIT_EN
    assign finish = last || hit;
`else
    assign finish = last;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            found <= 1'b0;
            index <= '0;
        end else begin
            done <= 1'b0;
            if (active) begin
                // NOTE: shreg and pos are pure datapath, always loaded by
                // start before use, so they carry no reset.
                shreg <= cur_word << 1;
                pos   <= cur_pos - N'(1);
                busy  <= !finish;
                done  <= finish;
                found <= cur_found || cur_word[W_N-1];
                if (hit) begin
                    index <= cur_pos;
                end else if (start) begin
                    index <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/two_term_weight_encoder.sv
// -----------------------------------------------------------------------------
// two_term_weight_encoder
// Recodes an unsigned weight w into the shift pair used by the shift-add
// multiplier: w ~= 2^b_i + 2^b_j, 2^b_i - 2^b_j, or 2^b_i alone, and reports
// the signed approximation error err = w - approx.
//
// Flow: IDLE -> SCAN_W (leading one p of w) -> RESID (choose plus/minus path,
// form residual r) -> SCAN_R (leading one q of r) -> ROUND (round q, build
// err) -> DONE. w == 0 exits from SCAN_W, exact powers of two exit from RESID.
// One tte_lod_scanner is shared by both scan phases.
//
// Optional build macro: TTE_EARLY_EXIT_EN (scans stop at the first set bit;
// results unchanged, latency variable).
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   w         in   W_N    unsigned weight
//   in_vld    in   weight valid
//   in_rdy    out  encoder can accept (IDLE only)
//   b_i       out  N      leading shift
//   b_j       out  N      second shift
//   one_term  out  product is a<<b_i only
//   b_sign    out  1: a<<b_i - a<<b_j, 0: sum
//   zero      out  w == 0, product is 0
//   err       out  W_N+2  two's-complement w - approx
//   out_vld   out  result valid
//   out_rdy   in   consumer accepts
// -----------------------------------------------------------------------------
module two_term_weight_encoder
    import tte_pkg::*;
#(
    parameter int W_N = TTE_W_N_DEFAULT,
    parameter int N   = TTE_N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W_N-1:0] w,
    input  logic           in_vld,
    output logic           in_rdy,
    output logic [N-1:0]   b_i,
    output logic [N-1:0]   b_j,
    output logic           one_term,
    output logic           b_sign,
    output logic           zero,
    output logic [W_N+1:0] err,
    output logic           out_vld,
    input  logic           out_rdy
);

    if (!tte_params_ok(W_N, N)) begin : g_bad_params
        $error("two_term_weight_encoder: 2**N must exceed W_N");
    end

    tte_state_t     state;
    logic           launch;     // first SCAN_W cycle: start the scanner on w_reg
    logic [W_N-1:0] w_reg;
    logic [N-1:0]   i_reg;
    logic           sign_reg;
    logic [W_N-1:0] r_reg;

    logic           scan_start;
    logic [W_N-1:0] scan_data;
    logic           scan_done;
    logic           scan_found;
    logic [N-1:0]   scan_index;

    // RESID datapath (scan_index holds p)
    logic [W_N:0]   w_x2;
    logic           minus;
    logic [W_N-1:0] pow_p;
    logic [W_N-1:0] pow_p1;
    logic [W_N-1:0] r_next;
    logic [N-1:0]   i_next;
    logic           exact;

    // ROUND datapath (scan_index holds q)
    logic [W_N:0]   r_x2;
    logic           round_up;
    logic [N-1:0]   j_next;
    logic [W_N+1:0] pow_i;
    logic [W_N+1:0] pow_j;
    logic [W_N+1:0] approx;
    logic [W_N+1:0] err_next;

    // Appending a zero LSB lets bit k of the doubled word stand for bit k-1
    // of the original, so "bit -1" reads as 0 with no special case for k == 0.
    assign w_x2  = {w_reg, 1'b0};
    assign minus = w_x2[scan_index];

    // The minus residual is 2^(p+1) - w. For p = W_N-1, 2^(p+1) wraps to 0
    // in W_N bits, and the modular difference is still exact because the
    // result never exceeds 2^(p-1).
    assign pow_p  = W_N'(1) << scan_index;
    assign pow_p1 = W_N'(1) << (scan_index + N'(1));
    assign r_next = minus ? (pow_p1 - w_reg) : (w_reg - pow_p);
    assign i_next = minus ? (scan_index + N'(1)) : scan_index;
    assign exact  = !minus && (r_next == '0);

    assign r_x2     = {r_reg, 1'b0};
    assign round_up = r_x2[scan_index];
    assign j_next   = scan_index + {{(N-1){1'b0}}, round_up};
    assign pow_i    = (W_N+2)'(1) << i_reg;
    assign pow_j    = (W_N+2)'(1) << j_next;
    assign approx   = sign_reg ? (pow_i - pow_j) : (pow_i + pow_j);
    assign err_next = {2'b00, w_reg} - approx;

    // The residual scan starts straight out of RESID on the combinational r.
    assign scan_start = launch || ((state == RESID) && !exact);
    assign scan_data  = (state == RESID) ? r_next : w_reg;

    tte_lod_scanner #(
        .W_N (W_N),
        .N   (N)
    ) u_scanner (
        .clk   (clk),
        .rst   (rst),
        .start (scan_start),
        .data  (scan_data),
        .done  (scan_done),
        .found (scan_found),
        .index (scan_index)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            launch   <= 1'b0;
            in_rdy   <= 1'b1;
            b_i      <= '0;
            b_j      <= '0;
            one_term <= 1'b0;
            b_sign   <= 1'b0;
            zero     <= 1'b0;
            err      <= '0;
            out_vld  <= 1'b0;
        end else begin
            launch <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_vld) begin
                        w_reg  <= w;
                        launch <= 1'b1;
                        in_rdy <= 1'b0;
                        state  <= SCAN_W;
                    end
                end
                SCAN_W: begin
                    if (scan_done) begin
                        if (!scan_found) begin
                            b_i      <= '0;
                            b_j      <= '0;
                            one_term <= 1'b1;
                            b_sign   <= 1'b0;
                            zero     <= 1'b1;
                            err      <= '0;
                            out_vld  <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= RESID;
                        end
                    end
                end
                RESID: begin
                    i_reg    <= i_next;
                    sign_reg <= minus;
                    r_reg    <= r_next;
                    if (exact) begin
                        b_i      <= scan_index;
                        b_j      <= '0;
                        one_term <= 1'b1;
                        b_sign   <= 1'b0;
                        zero     <= 1'b0;
                        err      <= '0;
                        out_vld  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        state <= SCAN_R;
                    end
                end
                SCAN_R: begin
                    if (scan_done) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    b_i      <= i_reg;
                    b_j      <= j_next;
                    one_term <= 1'b0;
                    b_sign   <= sign_reg;
                    zero     <= 1'b0;
                    err      <= err_next;
                    out_vld  <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    if (out_rdy) begin
                        out_vld <= 1'b0;
                        in_rdy  <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    in_rdy <= 1'b1;
                end
            endcase
        end
    end

endmodule
